// File: rtl/q2a03_pkg.sv
// Shared types and register addresses for the 2A03 bus blocks.
// Imported by the OAM DMA arbiter and its bus mux.
package q2a03_pkg;

  typedef logic [7:0]  reg8_type;
  typedef logic [15:0] reg16_type;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_type;

  localparam reg16_type REG_OAM_DMA  = 16'h4014;
  localparam reg16_type REG_OAM_DATA = 16'h2004;

  typedef struct packed {
    reg16_type addr;
    reg8_type  data;
    logic      rdwr;
  } bus_type;

endpackage

// File: rtl/dma_bus_mux.sv
// System bus source select between the 6502 core and the OAM DMA.
// Only READ and WRITE take the bus; all other states pass the core through.
module dma_bus_mux
  import q2a03_pkg::*;
#(
  parameter reg16_type OAM_DATA_ADDR = REG_OAM_DATA
) (
  input  dma_state_type state,
  input  reg8_type      page,
  input  reg8_type      idx,
  input  reg8_type      data_latch,
  input  bus_type       cpu_bus,
  output bus_type       sys_bus
);

  always_comb begin
    sys_bus = cpu_bus;
    unique case (1'b1)
      (state == READ): begin
        sys_bus.addr = {page, idx};
        sys_bus.rdwr = 1'b1;
      end
      (state == WRITE): begin
        sys_bus.addr = OAM_DATA_ADDR;
        sys_bus.data = data_latch;
        sys_bus.rdwr = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// 2A03 sprite DMA: halts the core and copies a page to OAM via $2004.
// Define Q2A03_DMA_STATS_EN to add the stall-length and transfer counters.
module oam_dma_arbiter
  import q2a03_pkg::*;
#(
  parameter reg16_type DMA_REG_ADDR  = REG_OAM_DMA,
  parameter reg16_type OAM_DATA_ADDR = REG_OAM_DATA,
  parameter int        XFER_LEN      = 256
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        G_cyc_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rdwr,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rd_data,
  output logic [15:0] G_addr,
  output logic [7:0]  G_wr_data,
  output logic        G_rdwr,
  input  logic [7:0]  G_rd_data,
  output logic        dma_active
`ifdef Q2A03_DMA_STATS_EN
  ,
  output logic [9:0]  dma_last_cycles,
  output logic [15:0] dma_count
`endif
);

  localparam reg8_type LAST_IDX = reg8_type'(XFER_LEN - 1);

  dma_state_type state;
  dma_state_type state_nxt;
  logic          parity;
  reg8_type      page;
  reg8_type      page_nxt;
  reg8_type      idx;
  reg8_type      idx_nxt;
  reg8_type      data_latch;
  reg8_type      latch_nxt;
  logic          trig;
  bus_type       cpu_bus;
  bus_type       sys_bus;

  assign trig = (cpu_addr == DMA_REG_ADDR) && !cpu_rdwr;

  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      state      <= IDLE;
      parity     <= 1'b0;
      page       <= '0;
      idx        <= '0;
      data_latch <= '0;
    end else if (G_cyc_en) begin
      state      <= state_nxt;
      parity     <= ~parity;
      page       <= page_nxt;
      idx        <= idx_nxt;
      data_latch <= latch_nxt;
    end
  end

  // Reads always land on GET cycles; a GET-parity halt read needs ALIGN.
  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    idx_nxt   = idx;
    latch_nxt = data_latch;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = HALT;
          page_nxt  = cpu_wr_data;
          idx_nxt   = '0;
        end
      end
      HALT: begin
        if (cpu_rdwr) state_nxt = parity ? READ : ALIGN;
      end
      ALIGN: state_nxt = READ;
      READ: begin
        latch_nxt = G_rd_data;
        state_nxt = WRITE;
      end
      WRITE: begin
        idx_nxt   = idx + 8'd1;
        state_nxt = (idx == LAST_IDX) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_bus = '{addr: cpu_addr, data: cpu_wr_data, rdwr: cpu_rdwr};

  dma_bus_mux #(
    .OAM_DATA_ADDR(OAM_DATA_ADDR)
  ) u_mux (
    .state     (state),
    .page      (page),
    .idx       (idx),
    .data_latch(data_latch),
    .cpu_bus   (cpu_bus),
    .sys_bus   (sys_bus)
  );

  assign G_addr      = sys_bus.addr;
  assign G_wr_data   = sys_bus.data;
  assign G_rdwr      = sys_bus.rdwr;
  assign cpu_rd_data = G_rd_data;
  assign cpu_ready   = (state == IDLE);
  assign dma_active  = (state != IDLE);

`ifdef Q2A03_DMA_STATS_EN
  logic [9:0] stall_cnt;

  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      stall_cnt       <= '0;
      dma_last_cycles <= '0;
      dma_count       <= '0;
    end else if (G_cyc_en) begin
      if (state == IDLE) stall_cnt <= '0;
      else               stall_cnt <= stall_cnt + 10'd1;
      if (state == WRITE && idx == LAST_IDX) begin
        dma_last_cycles <= stall_cnt + 10'd1;
        dma_count       <= dma_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Shares the 2A03 CPU bus between the 6502 core and the on-chip sprite (OAM) DMA engine.
- A CPU write to $4014 latches a source page. The block then halts the core through its ready input and copies 256 bytes from {page,00..FF} to the PPU OAM data port $2004.
- Sits between the core's bus pins and the external system bus, and owns the core's ready line.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA; written byte is the source page.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer; must be a power of two, at most 256.

Ports:
- G_clock  in  1  system clock; same clock as the CPU core.
- G_reset  in  1  asynchronous, active-low reset.
- G_cyc_en  in  1  one-G_clock strobe per CPU cycle, coincident with the core's phi2 falling-edge latch.
- cpu_addr  in  16  core address output.
- cpu_wr_data  in  8  core write data.
- cpu_rdwr  in  1  core R/W; 1=read, 0=write.
- cpu_ready  out  1  to core G_ready; 0 halts the core.
- cpu_rd_data  out  8  read data returned to the core.
- G_addr  out  16  system bus address.
- G_wr_data  out  8  system bus write data.
- G_rdwr  out  1  system bus R/W; 1=read.
- G_rd_data  in  8  system bus read data.
- dma_active  out  1  high while the block owns the bus or is waiting to own it.

Behaviour:
- Reset (async, G_reset=0) forces:
  - state=IDLE, cpu_ready=1, dma_active=0.
  - parity=0, idx=0, page=0, data_latch=0.
  - Bus outputs pass the CPU signals through combinationally.
  - Reset in any state aborts the transfer immediately; no partial-state retention.
- All state updates occur only on G_clock edges where G_cyc_en=1. One update equals one CPU cycle.
- parity toggles on every G_cyc_en. parity 0 is a GET cycle, parity 1 is a PUT cycle.
- States and transitions:
  - IDLE: bus is pass-through. Trigger is cpu_addr==DMA_REG_ADDR && cpu_rdwr==0 at G_cyc_en. On trigger: page<=cpu_wr_data, idx<=0, go to HALT. The write itself also passes to the bus.
  - HALT: cpu_ready=0, dma_active=1, bus is pass-through. The 6502 ignores RDY on write cycles, so the block stays in HALT while cpu_rdwr==0. At the first G_cyc_en with cpu_rdwr==1 (the core's repeated read), go to ALIGN if the next cycle is PUT, else to READ.
  - ALIGN: one dummy cycle; bus is pass-through with CPU read; then go to READ.
  - READ: G_addr={page,idx}, G_rdwr=1. At G_cyc_en: data_latch<=G_rd_data, go to WRITE.
  - WRITE: G_addr=OAM_DATA_ADDR, G_wr_data=data_latch, G_rdwr=0. At G_cyc_en: idx<=idx+1. If idx==XFER_LEN-1, go to IDLE; else go to READ.
- cpu_ready is 0 in HALT, ALIGN, READ and WRITE; it returns to 1 at the cycle boundary leaving the final WRITE.
- cpu_rd_data always equals G_rd_data.
- idx is 8 bits and wraps 0xFF->0x00. The source address never carries into the page.
- Total stall is 1 halt cycle + 512 transfer cycles, plus 1 align cycle when needed: 513 or 514 cycles, not counting extra HALT write cycles.
- Writes to DMA_REG_ADDR while not IDLE are ignored; the core is halted, so this is only reachable via a bus glitch.
- Simultaneous trigger and reset: reset wins.

Optional Feature:
- Macro: Q2A03_DMA_STATS_EN.
- Enabled: adds outputs dma_last_cycles[9:0] (stall length of the last completed transfer, counted in G_cyc_en cycles from HALT entry to IDLE return) and dma_count[15:0] (completed transfers, wrapping). Both reset to 0.
- Disabled: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package q2a03_pkg holds:
  - dma_state_type enum {IDLE, HALT, ALIGN, READ, WRITE}.
  - The 16-bit register address constants.
  - Shared reg8_type / reg16_type typedefs.
- One sub-module, dma_bus_mux: the combinational selection of G_addr/G_wr_data/G_rdwr between CPU and DMA, keyed by state.

Test Plan:
- CPU writes 8'h02 to $4014 on a GET-parity cycle, next cycle is a read -> no ALIGN. Reads $0200..$02FF, writes each byte to $2004 in order; cpu_ready low for exactly 513 cycles.
- Same trigger on a PUT-parity cycle -> one ALIGN cycle; cpu_ready low for exactly 514 cycles; first DMA read is at $0200.
- Trigger followed by two more core write cycles (e.g. inside RMW) -> HALT persists 3 cycles; transfer starts only after the first read cycle; 515 or 516 cycles total.
- Memory preloaded with $0300+i = i^8'hA5, page 8'h03 -> 256 bus writes to $2004 with data i^8'hA5. The last source address is $03FF with no carry to $0400.
- G_reset low during the byte-100 WRITE -> cpu_ready=1, dma_active=0 immediately. After release the block is IDLE with a pass-through bus and no further $2004 writes.
- With Q2A03_DMA_STATS_EN: two back-to-back transfers of 513 and 514 cycles -> dma_count=2, dma_last_cycles=514.
